// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encoding and fixed widths.
package cpu_ctrl_pkg;

  localparam int PC_W      = 10;
  localparam int RST_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_RUN    = 3'd2,
    ST_HALT   = 3'd3,
    ST_RESUME = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (dominant), count enable, and saturation at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (en && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the 16-bit-instruction core: sequences reset/run/halt/resume,
// detects halts from PC == NextPC, and faults runaway programs via a watchdog.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 2,
  parameter int          CW         = 16,
  parameter int unsigned WDOG_LIMIT = 16'hFFFF
) (
  input  logic            CLK,
  input  logic            RESET_L,
  input  logic            START,
  input  logic            CONT,
  input  logic            ABORT,
  input  logic [PC_W-1:0] CPU_PC,
  input  logic [PC_W-1:0] CPU_NEXTPC,
  output logic            CPU_RESET,
  output logic            CPU_EN_L,
  output logic            BUSY,
  output logic            HALTED,
  output logic            FAULT,
  output logic [PC_W-1:0] HALT_PC,
  output logic [CW-1:0]   CYCLES
);

  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);

  state_e                state_q, state_d;
  logic [RST_CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [PC_W-1:0]       halt_pc_q, halt_pc_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  cpu_en_l_q, cpu_en_l_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;

  logic                  start_clr;
  logic                  wdog_clr, wdog_en, wdog_expire;
  logic                  cyc_en;
  logic [CW-1:0]         wdog_cnt;

  // Widened compare so a narrow counter can never alias a large limit; the +1
  // counts the current RUN cycle, so FAULT follows exactly WDOG_LIMIT RUN cycles.
  assign wdog_expire = (33'(wdog_cnt) + 33'd1) >= 33'(WDOG_LIMIT);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    halt_pc_d = halt_pc_q;
    start_clr = 1'b0;

    if (ABORT) begin
      state_d = ST_IDLE;
    end else if (START) begin
      state_d   = ST_RST;
      rst_cnt_d = '0;
      halt_pc_d = '0;
      start_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_RST: begin
          if (rst_cnt_q == RST_LAST) state_d   = ST_RUN;
          else                       rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
        end
        ST_RUN: begin
          if (CPU_PC == CPU_NEXTPC) begin
            state_d   = ST_HALT;
            halt_pc_d = CPU_PC;
          end else if (wdog_expire) begin
            state_d   = ST_FAULT;
            halt_pc_d = CPU_PC;
          end
        end
        ST_HALT:   if (CONT) state_d = ST_RESUME;
        ST_RESUME: state_d = ST_RUN;
        default:   ;
      endcase
    end

    // Outputs are decoded from the next state and registered, so they are glitch-free.
    cpu_reset_d = (state_d inside {ST_IDLE, ST_RST, ST_FAULT});
    cpu_en_l_d  = (state_d != ST_RESUME);
    busy_d      = (state_d inside {ST_RST, ST_RUN, ST_RESUME});
    halted_d    = (state_d == ST_HALT);
    fault_d     = (state_d == ST_FAULT);
  end

  assign cyc_en   = (state_q inside {ST_RUN, ST_RESUME});
  assign wdog_en  = (state_q == ST_RUN);
  assign wdog_clr = start_clr || ((state_d == ST_RUN) && (state_q != ST_RUN));

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      halt_pc_q   <= '0;
      cpu_reset_q <= 1'b1;
      cpu_en_l_q  <= 1'b1;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      halt_pc_q   <= halt_pc_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_l_q  <= cpu_en_l_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
    end
  end

  sat_counter #(.W(CW)) u_cycles (
    .clk   (CLK),
    .rst_n (RESET_L),
    .clr   (start_clr),
    .en    (cyc_en),
    .cnt   (CYCLES)
  );

  sat_counter #(.W(CW)) u_wdog (
    .clk   (CLK),
    .rst_n (RESET_L),
    .clr   (wdog_clr),
    .en    (wdog_en),
    .cnt   (wdog_cnt)
  );

  assign CPU_RESET = cpu_reset_q;
  assign CPU_EN_L  = cpu_en_l_q;
  assign BUSY      = busy_q;
  assign HALTED    = halted_q;
  assign FAULT     = fault_q;
  assign HALT_PC   = halt_pc_q;

endmodule
